// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: hardwired control sequencer for three-register ALU
// instructions. Runs fetch steps T0..T2, then execute steps T3..T5, plus T6
// for MUL/DIV. All strobes are Moore outputs decoded from the registered
// state (and, in T1, the memory wait counter).
//
// Configuration macro: ALU_SEQ_MULDIV_EN
//   defined     - MUL (15) and DIV (16) are decoded; T6, LOin, HIin and
//                 Zhighout are active.
//   not defined - opcodes 15/16 are illegal; LOin, HIin, Zhighout and
//                 alu_sel[5:4] are constant 0; T6 is never entered.
module alu_op_sequencer #(
  parameter int NREG    = 16,  // general registers, 2..16
  parameter int MEM_LAT = 0    // extra memory read wait cycles, 0..7
) (
  input  logic            Clock,
  input  logic            Clear,
  input  logic            start,
  input  logic [31:0]     ir,
  output logic            PCout,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            MDRout,
  output logic            MARin,
  output logic            Zin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            LOin,
  output logic            HIin,
  output logic            IncPC,
  output logic            Read,
  output logic [NREG-1:0] Rout,
  output logic [NREG-1:0] Rin,
  output logic [5:0]      alu_sel,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_T5   = 3'd6;
  localparam logic [2:0] S_T6   = 3'd7;

`ifdef ALU_SEQ_MULDIV_EN
  localparam logic MULDIV_EN = 1'b1;
`else
  localparam logic MULDIV_EN = 1'b0;
`endif

  // Last value of the T1 wait counter before moving on to T2.
  localparam logic [2:0]      LAST_WAIT = 3'(MEM_LAT);
  localparam logic [NREG-1:0] ONE_HOT0  = NREG'(1);

  logic [2:0] state_q, state_d;
  logic [2:0] wait_q,  wait_d;
  logic [3:0] ra_q,    ra_d;
  logic [3:0] rc_q,    rc_d;
  logic [5:0] op_q,    op_d;   // decoded one-hot ALU op, held through T4..T6

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic [5:0] dec_sel;
  logic       dec_legal;
  logic       is_muldiv;
  logic       final_step;

  // The low IR bits carry no information for register-register ops.
  logic unused_ir;
  assign unused_ir = ^ir[14:0];

  assign opcode = ir[31:27];
  assign ra     = ir[26:23];
  assign rb     = ir[22:19];
  assign rc     = ir[18:15];

  assign is_muldiv  = MULDIV_EN && (op_q[5:4] != 2'b00);
  assign final_step = ((state_q == S_T5) && !is_muldiv) || (state_q == S_T6);

  // Instruction decode: opcode to one-hot ALU select, plus legality.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    dec_sel   = 6'b000000;
    dec_legal = 1'b1;
    case (opcode)
      5'd3:  dec_sel = 6'b000001;
      5'd4:  dec_sel = 6'b000010;
      5'd5:  dec_sel = 6'b000100;
      5'd6:  dec_sel = 6'b001000;
`ifdef ALU_SEQ_MULDIV_EN
      5'd15: dec_sel = 6'b010000;
      5'd16: dec_sel = 6'b100000;
`endif
      default: dec_legal = 1'b0;
    endcase
    if (int'(ra) >= NREG || int'(rb) >= NREG || int'(rc) >= NREG) begin
      dec_legal = 1'b0;
    end
  end

  // Next-state logic; register fields are captured in T3 so T4..T6 do not
  // depend on the IR staying stable.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ra_d    = ra_q;
    rc_d    = rc_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        wait_d  = 3'd0;
      end
      S_T1: begin
        if (wait_q == LAST_WAIT) begin
          state_d = S_T2;
          wait_d  = 3'd0;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (dec_legal) begin
          state_d = S_T4;
          ra_d    = ra;
          rc_d    = rc;
          op_d    = dec_sel;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (is_muldiv)  state_d = S_T6;
        else if (start) state_d = S_T0;
        else            state_d = S_IDLE;
      end
      S_T6: state_d = start ? S_T0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous clear taking priority over everything.
  always_ff @(posedge Clock) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (Clear) begin
      state_q <= S_IDLE;
      wait_q  <= 3'd0;
      ra_q    <= 4'd0;
      rc_q    <= 4'd0;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ra_q    <= ra_d;
      rc_q    <= rc_d;
      op_q    <= op_d;
    end
  end

  // Moore output decode of the current step.
  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Rout     = '0;
    Rin      = '0;
    alu_sel  = 6'b000000;
    illegal  = 1'b0;
    busy     = (state_q != S_IDLE);
    done     = final_step;
    case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        PCin    = (wait_q == 3'd0);
        MDRin   = (wait_q == LAST_WAIT);
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (dec_legal) begin
          Rout = ONE_HOT0 << rb;
          Yin  = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        Rout    = ONE_HOT0 << rc_q;
        Zin     = 1'b1;
        alu_sel = {op_q[5:4] & {2{MULDIV_EN}}, op_q[3:0]};
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) LOin = 1'b1;
        else           Rin  = ONE_HOT0 << ra_q;
      end
      S_T6: begin
        Zhighout = MULDIV_EN;
        HIin     = MULDIV_EN;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer. Three instances run side by side
// (MEM_LAT=0/NREG=16, MEM_LAT=2/NREG=16, MEM_LAT=0/NREG=8) sharing inputs;
// each scenario pushes the expected per-cycle output trace into a queue
// when it launches an instruction and compares it cycle by cycle.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  typedef struct packed {
    logic [13:0] st;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [5:0]  sel;
    logic        busy;
    logic        done;
    logic        ill;
  } obs_t;

  // Bit positions inside obs_t.st
  localparam int PCOUT = 13, ZLOWOUT = 12, ZHIGHOUT = 11, MDROUT = 10;
  localparam int MARIN = 9, ZIN = 8, PCIN = 7, MDRIN = 6, IRIN = 5, YIN = 4;
  localparam int LOIN = 3, HIIN = 2, INCPC = 1, READ = 0;

  logic        clk   = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir    = 32'd0;

  wire [13:0] st0, st2, st8;
  wire [15:0] rout0, rin0, rout2, rin2;
  wire [7:0]  rout8, rin8;
  wire [5:0]  sel0, sel2, sel8;
  wire        busy0, done0, ill0, busy2, done2, ill2, busy8, done8, ill8;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.NREG(16), .MEM_LAT(0)) dut0 (
    .Clock(clk), .Clear(clear), .start(start), .ir(ir),
    .PCout(st0[PCOUT]), .Zlowout(st0[ZLOWOUT]), .Zhighout(st0[ZHIGHOUT]),
    .MDRout(st0[MDROUT]), .MARin(st0[MARIN]), .Zin(st0[ZIN]), .PCin(st0[PCIN]),
    .MDRin(st0[MDRIN]), .IRin(st0[IRIN]), .Yin(st0[YIN]), .LOin(st0[LOIN]),
    .HIin(st0[HIIN]), .IncPC(st0[INCPC]), .Read(st0[READ]),
    .Rout(rout0), .Rin(rin0), .alu_sel(sel0),
    .busy(busy0), .done(done0), .illegal(ill0)
  );

  alu_op_sequencer #(.NREG(16), .MEM_LAT(2)) dut2 (
    .Clock(clk), .Clear(clear), .start(start), .ir(ir),
    .PCout(st2[PCOUT]), .Zlowout(st2[ZLOWOUT]), .Zhighout(st2[ZHIGHOUT]),
    .MDRout(st2[MDROUT]), .MARin(st2[MARIN]), .Zin(st2[ZIN]), .PCin(st2[PCIN]),
    .MDRin(st2[MDRIN]), .IRin(st2[IRIN]), .Yin(st2[YIN]), .LOin(st2[LOIN]),
    .HIin(st2[HIIN]), .IncPC(st2[INCPC]), .Read(st2[READ]),
    .Rout(rout2), .Rin(rin2), .alu_sel(sel2),
    .busy(busy2), .done(done2), .illegal(ill2)
  );

  alu_op_sequencer #(.NREG(8), .MEM_LAT(0)) dut8 (
    .Clock(clk), .Clear(clear), .start(start), .ir(ir),
    .PCout(st8[PCOUT]), .Zlowout(st8[ZLOWOUT]), .Zhighout(st8[ZHIGHOUT]),
    .MDRout(st8[MDROUT]), .MARin(st8[MARIN]), .Zin(st8[ZIN]), .PCin(st8[PCIN]),
    .MDRin(st8[MDRIN]), .IRin(st8[IRIN]), .Yin(st8[YIN]), .LOin(st8[LOIN]),
    .HIin(st8[HIIN]), .IncPC(st8[INCPC]), .Read(st8[READ]),
    .Rout(rout8), .Rin(rin8), .alu_sel(sel8),
    .busy(busy8), .done(done8), .illegal(ill8)
  );

  // which: 0 = dut0, 1 = dut2, 2 = dut8
  function automatic obs_t get_obs(input int which);
    obs_t o;
    case (which)
      1:       o = '{st2, rout2, rin2, sel2, busy2, done2, ill2};
      2:       o = '{st8, {8'h00, rout8}, {8'h00, rin8}, sel8, busy8, done8, ill8};
      default: o = '{st0, rout0, rin0, sel0, busy0, done0, ill0};
    endcase
    return o;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  // Reference model: expected trace from T0 through the last busy step.
  task automatic push_seq(input logic [31:0] v, input int lat, input int nreg);
    logic [4:0] opc;
    int         a, b, c;
    logic [5:0] sel;
    bit         legal, md;
    obs_t       o;
    opc = v[31:27];
    a = int'(v[26:23]);
    b = int'(v[22:19]);
    c = int'(v[18:15]);
    legal = 1'b1;
    md = 1'b0;
    sel = 6'd0;
    case (opc)
      5'd3: sel = 6'b000001;
      5'd4: sel = 6'b000010;
      5'd5: sel = 6'b000100;
      5'd6: sel = 6'b001000;
`ifdef ALU_SEQ_MULDIV_EN
      5'd15: begin sel = 6'b010000; md = 1'b1; end
      5'd16: begin sel = 6'b100000; md = 1'b1; end
`endif
      default: legal = 1'b0;
    endcase
    if (a >= nreg || b >= nreg || c >= nreg) legal = 1'b0;
    // T0
    o = '0; o.busy = 1'b1;
    o.st[PCOUT] = 1'b1; o.st[MARIN] = 1'b1; o.st[INCPC] = 1'b1; o.st[ZIN] = 1'b1;
    exp_q.push_back(o);
    // T1, MEM_LAT+1 cycles
    for (int i = 0; i <= lat; i++) begin
      o = '0; o.busy = 1'b1;
      o.st[ZLOWOUT] = 1'b1; o.st[READ] = 1'b1;
      o.st[PCIN]  = (i == 0);
      o.st[MDRIN] = (i == lat);
      exp_q.push_back(o);
    end
    // T2
    o = '0; o.busy = 1'b1; o.st[MDROUT] = 1'b1; o.st[IRIN] = 1'b1;
    exp_q.push_back(o);
    // T3
    o = '0; o.busy = 1'b1;
    if (!legal) begin
      o.ill = 1'b1;
      exp_q.push_back(o);
      return;
    end
    o.rout = 16'd1 << b; o.st[YIN] = 1'b1;
    exp_q.push_back(o);
    // T4
    o = '0; o.busy = 1'b1; o.rout = 16'd1 << c; o.st[ZIN] = 1'b1; o.sel = sel;
    exp_q.push_back(o);
    // T5 (and T6)
    o = '0; o.busy = 1'b1; o.st[ZLOWOUT] = 1'b1;
    if (md) begin
      o.st[LOIN] = 1'b1;
      exp_q.push_back(o);
      o = '0; o.busy = 1'b1; o.st[ZHIGHOUT] = 1'b1; o.st[HIIN] = 1'b1; o.done = 1'b1;
      exp_q.push_back(o);
    end else begin
      o.rin = 16'd1 << a; o.done = 1'b1;
      exp_q.push_back(o);
    end
  endtask

  task automatic push_idle();
    obs_t o;
    o = '0;
    exp_q.push_back(o);
  endtask

  // Launch an instruction and drain the scoreboard one cycle per entry.
  // start drops after `hold` samples; Clear pulses after sample `clear_at`.
  task automatic run(input string name, input int which, input logic [31:0] v,
                     input int hold, input int clear_at);
    int   idx;
    obs_t got, exp;
    idx = 0;
    @(negedge clk);
    ir = v;
    start = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      got = get_obs(which);
      exp = exp_q.pop_front();
      idx++;
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s step %0d: got st=%b rout=%h rin=%h sel=%b busy=%b done=%b ill=%b; expected st=%b rout=%h rin=%h sel=%b busy=%b done=%b ill=%b",
                 name, idx, got.st, got.rout, got.rin, got.sel, got.busy, got.done, got.ill,
                 exp.st, exp.rout, exp.rin, exp.sel, exp.busy, exp.done, exp.ill);
      end
      if (idx >= hold) start = 1'b0;
      clear = (idx == clear_at);
    end
    start = 1'b0;
    clear = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t got;
    clear = 1'b1;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      got = get_obs(w);
      n_checks++;
      if (got !== obs_t'(0)) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %h, expected all zero", w, got);
      end
    end
    clear = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_sub();
    push_seq(32'h22920000, 0, 16);
    push_idle();
    run("sub_lat0", 0, 32'h22920000, 1, -1);
    idle_cycles(6);
  endtask

  task automatic test_mem_lat();
    logic [31:0] v;
    v = mk_ir(5'd3, 4'd7, 4'd1, 4'd9);
    push_seq(v, 2, 16);
    push_idle();
    run("add_lat2", 1, v, 1, -1);
    idle_cycles(6);
  endtask

  task automatic test_alu_ops();
    logic [31:0] v;
    v = mk_ir(5'd5, 4'd3, 4'd3, 4'd3);   // AND, Ra=Rb=Rc
    push_seq(v, 0, 16);
    push_idle();
    run("and_same_regs", 0, v, 1, -1);
    idle_cycles(6);
    v = mk_ir(5'd6, 4'd15, 4'd0, 4'd15); // OR, edge register indices
    push_seq(v, 0, 16);
    push_idle();
    run("or_edges", 0, v, 1, -1);
    idle_cycles(6);
  endtask

  task automatic test_muldiv();
    logic [31:0] v;
    v = mk_ir(5'd15, 4'd0, 4'd2, 4'd4);
    push_seq(v, 0, 16);
    push_idle();
    run("mul", 0, v, 1, -1);
    idle_cycles(6);
    v = mk_ir(5'd16, 4'd1, 4'd3, 4'd5);
    push_seq(v, 2, 16);
    push_idle();
    run("div_lat2", 1, v, 1, -1);
    idle_cycles(6);
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    v = mk_ir(5'h1F, 4'd1, 4'd2, 4'd3);
    push_seq(v, 0, 16);
    push_idle();
    run("bad_opcode", 0, v, 1, -1);
    idle_cycles(6);
    v = mk_ir(5'd3, 4'd9, 4'd1, 4'd2);
    push_seq(v, 0, 8);
    push_idle();
    run("nreg8_ra9", 2, v, 1, -1);
    idle_cycles(6);
    v = mk_ir(5'd4, 4'd1, 4'd2, 4'd8);
    push_seq(v, 0, 8);
    push_idle();
    run("nreg8_rc8", 2, v, 1, -1);
    idle_cycles(6);
  endtask

  task automatic test_clear();
    // T0..T4 then Clear: the cycle after the Clear edge must be idle.
    push_seq(32'h22920000, 0, 16);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    push_idle();
    run("clear_in_t4", 0, 32'h22920000, 1, 5);
    idle_cycles(2);
    push_seq(32'h22920000, 0, 16);
    push_idle();
    run("after_clear", 0, 32'h22920000, 1, -1);
    idle_cycles(6);
  endtask

  task automatic test_back_to_back();
    int len;
    push_seq(32'h22920000, 0, 16);
    push_seq(32'h22920000, 0, 16);
    len = exp_q.size();
    push_idle();
    run("back_to_back", 0, 32'h22920000, len, -1);
    idle_cycles(6);
  endtask

  initial begin
    test_reset();
    test_sub();
    test_mem_lat();
    test_alu_ops();
    test_muldiv();
    test_illegal();
    test_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Hardwired control sequencer that drives the datapath's register-transfer strobes for three-register ALU instructions. It runs the fetch steps T0–T2, then the execute steps T3–T5, plus T6 for MUL/DIV. It replaces the hand-written per-instruction control sequences, and generalises them over register count, memory read latency and operation. It sits between the instruction register and the datapath control inputs.

## Interface
Parameters:
- NREG, 16, number of general registers (2..16); width of `Rout`/`Rin`.
- MEM_LAT, 0, extra wait cycles for a memory read (0..7).

Ports:
- Clock  in  1  single clock; everything updates on the rising edge.
- Clear  in  1  synchronous, active-high reset.
- start  in  1  request to execute one instruction.
- ir  in  32  IR contents. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus-drive strobes.
- MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin  out  1 each  register-load strobes.
- IncPC, Read  out  1 each  ALU increment and memory read.
- Rout  out  NREG  one-hot register bus drive.
- Rin  out  NREG  one-hot register load.
- alu_sel  out  6  one-hot ALU op: [0]ADD [1]SUB [2]AND [3]OR [4]MUL [5]DIV.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  high during the final step of an instruction.
- illegal  out  1  one-cycle pulse on an undecodable instruction.

## Operation
- Opcodes: ADD=3, SUB=4, AND=5, OR=6, MUL=15, DIV=16. Any other opcode is illegal.
- An Ra, Rb or Rc index ≥ NREG is illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- All outputs are Moore outputs, decoded from the registered state and, in T1, the wait counter.
- IDLE: all strobes 0. If `start`=1, the next state is T0.
- T0: PCout, MARin, IncPC, Zin.
- T1: lasts MEM_LAT+1 cycles.
  - Zlowout and Read are held for the whole of T1.
  - PCin is asserted in the first T1 cycle only.
  - MDRin is asserted in the last T1 cycle only.
- T2: MDRout, IRin. `ir` is valid from T3 onward.
- T3: decode `ir`.
  - Legal: assert Rout[Rb] and Yin.
  - Illegal: assert only `illegal`; the next state is IDLE.
- T4: Rout[Rc], Zin, and alu_sel set to the decoded op.
- T5:
  - ADD/SUB/AND/OR: Zlowout, Rin[Ra], done.
  - MUL/DIV: Zlowout, LOin.
- T6 (MUL/DIV only): Zhighout, HIin, done. Ra is ignored for MUL/DIV.
- After the done step:
  - `start`=1: go directly to T0 (back-to-back).
  - otherwise: go to IDLE.
- `start` is ignored in every state except IDLE and the done step.

## Timing
- Reset values: all outputs 0; state IDLE; wait counter 0.
- Clear has priority over every transition. If asserted mid-instruction, the cycle after the Clear edge is IDLE with all strobes 0. No partial Rin/LOin/HIin is issued.
- Datapath registers latch at the rising edge that ends the cycle in which their load strobe is high.
- Latency from the cycle `start` is sampled to `done`:
  - ALU op: 6+MEM_LAT cycles.
  - MUL/DIV: 7+MEM_LAT cycles.
- Only one Rout bit, and at most one bus-drive strobe, is ever high in a cycle.
- Ra=Rb or Ra=Rc is legal. The write happens in T5, after both reads.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined:
  - MUL/DIV are decoded.
  - T6, LOin, HIin and Zhighout are active.
- Not defined:
  - Opcodes 15 and 16 are illegal, with the T3 `illegal` pulse.
  - T6 does not exist.
  - LOin, HIin and Zhighout are tied to 0.
  - alu_sel[5:4] is tied to 0.

## Test plan
- SUB, MEM_LAT=0, `ir`=0x22920000 (R5=R2−R4), start pulsed for one cycle. Required:
  - T3: Rout=0x0004 with Yin.
  - T4: Rout=0x0010, alu_sel=6'b000010, Zin.
  - T5: Rin=0x0020 with Zlowout and done.
  - 6th cycle after start; IDLE next.
- MEM_LAT=2, ADD. Required:
  - T1 lasts 3 cycles; Read held for all 3.
  - PCin in cycle 1 only; MDRin in cycle 3 only.
  - done in the 8th cycle.
- MUL (opcode 15, Rb=2, Rc=4) with the macro defined. Required:
  - T5: LOin with Zlowout.
  - T6: HIin with Zhighout and done.
  - No Rin bit is ever set.
  - Without the macro: `illegal` pulses in T3 and the block is back in IDLE the next cycle.
- Opcode 0x1F, and separately NREG=8 with Ra=9. Required: `illegal` pulse in T3, IDLE next cycle, `done` never asserted, Rin stays 0.
- Clear asserted during T4. Required: the next cycle has all outputs 0 and busy=0; a new `start` then runs a full sequence correctly.
- `start` held high across two SUBs. Required: T0 follows the first `done` cycle immediately; the second `done` comes exactly 6 cycles later.
